// File: rtl/cw_packer.sv
// cw_packer: packs fixed-width codewords into a byte stream.
//
// Codewords arrive as one-cycle strobes (no backpressure) and are buffered in a
// small FIFO. A bit accumulator holds up to 7 residual bits plus one codeword.
// Bytes are taken MSB-first from the top of the accumulator. At the end of a
// message, any residual bits go out as one left-justified, zero-padded byte,
// and pack_done then pulses for one cycle.
//
// Ports
//   clk, rst    clock; asynchronous active-high reset
//   cw_in       codeword, qualified by cw_rdy
//   cw_rdy      one-cycle strobe per codeword
//   cw_done     one-cycle strobe after the upstream's last codeword
//   byte_out    packed byte, bit 7 = earliest codeword bit
//   byte_valid  byte_out holds a byte
//   byte_ready  downstream accepts (transfer = byte_valid & byte_ready)
//   pack_done   one-cycle pulse after the final byte of a message transfers
//   overflow    sticky: a codeword was dropped
//   cnt_err     sticky: cw_done arrived with a word count other than NUM_CW
module cw_packer #(
    parameter int CW_W   = 13,
    parameter int NUM_CW = 10,
    parameter int QDEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CW_W-1:0] cw_in,
    input  logic            cw_rdy,
    input  logic            cw_done,
    output logic [7:0]      byte_out,
    output logic            byte_valid,
    input  logic            byte_ready,
    output logic            pack_done,
    output logic            overflow,
    output logic            cnt_err
);
    localparam int ACC_W  = CW_W + 7;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int AW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W  = $clog2(NUM_CW + 1);

    localparam logic [FILL_W-1:0] FILL_8  = FILL_W'(8);
    localparam logic [FILL_W-1:0] FILL_7  = FILL_W'(7);
    localparam logic [FILL_W-1:0] FILL_CW = FILL_W'(CW_W);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(NUM_CW);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

    state_t              state_q;
    logic [CW_W-1:0]     mem_q [QDEPTH];
    logic [AW:0]         wr_ptr_q, rd_ptr_q;
    logic [ACC_W-1:0]    acc_q;
    logic [FILL_W-1:0]   fill_q;
    logic [CNT_W-1:0]    rx_cnt_q;   // words accepted for the current message
    logic [CNT_W-1:0]    nxt_cnt_q;  // words accepted during DONE for the next one
    logic [CNT_W-1:0]    pop_cnt_q;  // words of the current message consumed
    logic [7:0]          byte_q;
    logic                byte_valid_q, pack_done_q, ovf_q, cnt_err_q;

    logic                q_empty, q_full, out_free, emit_col, emit_fl, pop;
    logic                in_done, msg_full, push_ok, drop;
    logic [CW_W-1:0]     head;
    logic [ACC_W-1:0]    acc_after, app, acc_d;
    logic [FILL_W-1:0]   fill_after, fill_d;
    logic [CNT_W-1:0]    eff_cnt;

    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        out_free   = !byte_valid_q || byte_ready;
        emit_col   = (state_q == S_COLLECT) && (fill_q >= FILL_8) && out_free;
        emit_fl    = (state_q == S_FLUSH) && (fill_q != '0) && out_free;
        fill_after = fill_q;
        acc_after  = acc_q;
        if (emit_col) begin
            fill_after = fill_q - FILL_8;
            acc_after  = acc_q << 8;
        end else if (emit_fl) begin
            fill_after = '0;
            acc_after  = '0;
        end
        // The pop decision looks at the fill left after this cycle's emission,
        // so a byte can leave and a codeword arrive in the same cycle; that is
        // what keeps the output at one byte per cycle.
        pop = (state_q == S_COLLECT) && (pop_cnt_q != CNT_MAX) && !q_empty &&
              (fill_after <= FILL_7);
        // Place the new word directly below the residual bits.
        app    = ACC_W'({head, 7'b0}) >> fill_after;
        acc_d  = pop ? (acc_after | app) : acc_after;
        fill_d = pop ? (fill_after + FILL_CW) : fill_after;

        // Strobes during DONE belong to the next message and use their own count.
        in_done  = (state_q == S_DONE);
        msg_full = in_done ? (nxt_cnt_q == CNT_MAX) : (rx_cnt_q == CNT_MAX);
        push_ok  = cw_rdy && !msg_full && (!q_full || pop);
        drop     = cw_rdy && !push_ok;
        eff_cnt  = rx_cnt_q + CNT_W'(push_ok && !in_done);
    end

    // Queue storage: no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= cw_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            acc_q        <= '0;
            fill_q       <= '0;
            rx_cnt_q     <= '0;
            nxt_cnt_q    <= '0;
            pop_cnt_q    <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            pack_done_q  <= 1'b0;
            ovf_q        <= 1'b0;
            cnt_err_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                pop_cnt_q <= pop_cnt_q + 1'b1;
            end
            acc_q  <= acc_d;
            fill_q <= fill_d;

            if (emit_col || emit_fl) begin
                byte_q       <= acc_q[ACC_W-1 -: 8];
                byte_valid_q <= 1'b1;
            end else if (byte_ready) begin
                byte_valid_q <= 1'b0;
            end

            ovf_q       <= ovf_q | drop;
            cnt_err_q   <= cnt_err_q | (cw_done && (eff_cnt != CNT_MAX));
            pack_done_q <= 1'b0;

            if (push_ok) begin
                if (in_done) nxt_cnt_q <= nxt_cnt_q + 1'b1;
                else         rx_cnt_q  <= rx_cnt_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    // rx_cnt_q is nonzero when words were queued during DONE.
                    if (cw_rdy || (rx_cnt_q != '0)) state_q <= S_COLLECT;
                end
                S_COLLECT: begin
                    if ((pop_cnt_q == CNT_MAX) && q_empty && (fill_q < FILL_8))
                        state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    // With residual bits, leave only once the padded byte is loaded.
                    if ((fill_q == '0) || out_free) state_q <= S_DONE;
                end
                S_DONE: begin
                    // out_free: the last byte is gone or transfers this cycle.
                    if (out_free) begin
                        pack_done_q <= 1'b1;
                        state_q     <= S_IDLE;
                        rx_cnt_q    <= nxt_cnt_q + CNT_W'(push_ok);
                        nxt_cnt_q   <= '0;
                        pop_cnt_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = byte_valid_q;
    assign pack_done  = pack_done_q;
    assign cnt_err    = cnt_err_q;
    // The drop is visible in the same cycle as the offending strobe.
    assign overflow   = ovf_q | (drop & ~rst);

endmodule

// File: tb/tb_cw_packer.sv
// Directed testbench for cw_packer (default parameters).
module tb_cw_packer;
    logic        clk = 1'b0;
    logic        rst, cw_rdy, cw_done, byte_ready;
    logic [12:0] cw_in;
    logic [7:0]  byte_out;
    logic        byte_valid, pack_done, overflow, cnt_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] got [$];
    int pd_cnt     = 0;
    int pd_at_size = 0;

    // Word pattern Q: even words all ones, odd words all zeros.
    logic [7:0] QB [17] = '{8'hFF, 8'hF8, 8'h00, 8'h3F, 8'hFE, 8'h00, 8'h0F, 8'hFF, 8'h80,
                            8'h03, 8'hFF, 8'hE0, 8'h00, 8'hFF, 8'hF8, 8'h00, 8'h00};
    // Word pattern P: even words all zeros, odd words all ones.
    logic [7:0] PB [17] = '{8'h00, 8'h07, 8'hFF, 8'hC0, 8'h01, 8'hFF, 8'hF0, 8'h00, 8'h7F,
                            8'hFC, 8'h00, 8'h1F, 8'hFF, 8'h00, 8'h07, 8'hFF, 8'hC0};

    cw_packer dut (
        .clk        (clk),
        .rst        (rst),
        .cw_in      (cw_in),
        .cw_rdy     (cw_rdy),
        .cw_done    (cw_done),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pack_done  (pack_done),
        .overflow   (overflow),
        .cnt_err    (cnt_err)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so the negedge sees this cycle's values.
    always @(negedge clk) begin
        if (!rst && byte_valid && byte_ready) got.push_back(byte_out);
        if (!rst && pack_done) begin
            pd_cnt++;
            pd_at_size = got.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] word(input int sel, input int i);
        case (sel)
            0:       return 13'h1FFF;
            1:       return (i == 0) ? 13'h1000 : 13'h0000;
            2:       return (i % 2 == 0) ? 13'h1FFF : 13'h0000;
            default: return (i % 2 == 1) ? 13'h1FFF : 13'h0000;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input int sel, input int i);
        case (sel)
            0:       return (i == 16) ? 8'hC0 : 8'hFF;
            1:       return (i == 0) ? 8'h80 : 8'h00;
            2:       return QB[i];
            default: return PB[i];
        endcase
    endfunction

    task automatic send_words(input int sel, input int first, input int last, input bit done_last);
        for (int i = first; i <= last; i++) begin
            cw_in   = word(sel, i);
            cw_rdy  = 1'b1;
            cw_done = done_last && (i == last);
            $display("t=%0t send word %0d = %h", $time, i, cw_in);
            tick();
            cw_rdy  = 1'b0;
            cw_done = 1'b0;
            cw_in   = '0;
        end
    endtask

    task automatic pulse_done();
        cw_done = 1'b1;
        tick();
        cw_done = 1'b0;
    endtask

    task automatic wait_pd(input string tag, input int target);
        int n = 0;
        while (pd_cnt < target && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_pack_done_seen"}, pd_cnt, target);
    endtask

    task automatic check_msg(input string tag, input int sel, input int base, input int pd_base);
        wait_pd(tag, pd_base + 1);
        tick(); tick(); tick();
        chk({tag, "_byte_count"}, got.size() - base, 17);
        chk({tag, "_pd_after_last"}, pd_at_size - base, 17);
        chk({tag, "_pd_one_pulse"}, pd_cnt, pd_base + 1);
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = (base + i < got.size()) ? got[base + i] : 8'hxx;
            $display("t=%0t %s byte %0d = %h (expect %h)", $time, tag, i, b, exp_byte(sel, i));
            chk($sformatf("%s_byte%0d", tag, i), b, exp_byte(sel, i));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int base, pd_base, n;
        rst = 1'b1; cw_rdy = 1'b0; cw_done = 1'b0; cw_in = '0; byte_ready = 1'b1;
        tick(); tick();
        chk("rst_byte_out", byte_out, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_pack_done", pack_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cnt_err", cnt_err, 0);
        rst = 1'b0;
        tick();

        // All-ones message, cw_done the cycle after the 10th word.
        base = got.size(); pd_base = pd_cnt;
        send_words(0, 0, 9, 1'b0);
        pulse_done();
        check_msg("ones", 0, base, pd_base);
        chk("ones_cnt_err", cnt_err, 0);
        chk("ones_overflow", overflow, 0);

        // Single leading one; cw_done in the same cycle as the 10th word.
        base = got.size(); pd_base = pd_cnt;
        send_words(1, 0, 9, 1'b1);
        check_msg("lead1", 1, base, pd_base);
        chk("lead1_cnt_err", cnt_err, 0);

        // Output stalled while 5 words arrive back-to-back.
        base = got.size(); pd_base = pd_cnt;
        byte_ready = 1'b0;
        send_words(2, 0, 4, 1'b0);
        chk("stall_overflow", overflow, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", byte_valid, 1);
            chk("stall_hold", byte_out, 8'hFF);
            tick();
        end
        byte_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        send_words(2, 5, 9, 1'b0);
        pulse_done();
        check_msg("stall", 2, base, pd_base);
        chk("stall_overflow_end", overflow, 0);
        chk("stall_cnt_err", cnt_err, 0);

        // Output stalled while 7 words arrive: the 7th is dropped.
        byte_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cw_in = 13'h0AAA; cw_rdy = 1'b1;
            #1;
            $display("t=%0t strobe %0d overflow=%0b", $time, i, overflow);
            chk($sformatf("ovf_strobe%0d", i), overflow, (i == 6) ? 1 : 0);
            @(posedge clk); #1;
            cw_rdy = 1'b0; cw_in = '0;
        end
        for (int i = 0; i < 5; i++) tick();
        chk("ovf_sticky_stall", overflow, 1);
        byte_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("ovf_sticky_release", overflow, 1);
        rst = 1'b1;
        #1;
        chk("ovf_cleared_by_rst", overflow, 0);
        tick();
        rst = 1'b0;
        tick();

        // cw_done after 9 words: count error, message still waits for word 10.
        base = got.size(); pd_base = pd_cnt;
        send_words(0, 0, 8, 1'b0);
        pulse_done();
        tick();
        chk("cnterr_set", cnt_err, 1);
        for (int i = 0; i < 40; i++) tick();
        chk("cnterr_no_pd", pd_cnt, pd_base);
        send_words(0, 9, 9, 1'b0);
        check_msg("cnterr", 0, base, pd_base);
        chk("cnterr_sticky", cnt_err, 1);

        // Reset in the middle of a message, then a clean full message.
        base = got.size();
        send_words(0, 0, 3, 1'b0);
        n = 0;
        while (got.size() < base + 6 && n < 100) begin
            tick();
            n++;
        end
        tick(); tick(); tick();
        chk("mid_bytes_before_rst", got.size() - base, 6);
        chk("mid_byte_out_before_rst", byte_out, 8'hFF);
        rst = 1'b1;
        #1;
        chk("mid_rst_byte_out", byte_out, 0);
        chk("mid_rst_byte_valid", byte_valid, 0);
        chk("mid_rst_pack_done", pack_done, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_cnt_err", cnt_err, 0);
        tick();
        rst = 1'b0;
        tick();
        base = got.size(); pd_base = pd_cnt;
        send_words(3, 0, 9, 1'b0);
        pulse_done();
        check_msg("after_rst", 3, base, pd_base);
        chk("after_rst_cnt_err", cnt_err, 0);
        chk("after_rst_overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
